// File: rtl/median_ctrl_pkg.sv
// median_ctrl_pkg: shared state encoding and parameter limits for the median stream controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package median_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int LAT_MIN       = 0;
  localparam int LAT_MAX       = 8;
  localparam int OUT_DEPTH_MIN = 2;
  localparam int OUT_DEPTH_MAX = 16;

  // Wide enough for buffer occupancy plus every in-flight issue at the limits.
  localparam int CNT_W = 6;

endpackage

// File: rtl/median_res_fifo.sv
// median_res_fifo: in-order result buffer between the median core and the consumer.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: none internally; the caller guarantees no push into a full buffer unless popping.
module median_res_fifo #(
  parameter int WIDTH     = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic [$clog2(OUT_DEPTH):0]   occ
);

  localparam int PW = $clog2(OUT_DEPTH);

  logic [WIDTH-1:0] mem [OUT_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty    = (occ == '0);
  assign do_pop   = pop && !empty;
  // Drive zero while empty so the output is clean under and after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; contents are only observed through valid entries, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/median_stream_ctrl.sv
// median_stream_ctrl: runs count-long median jobs, pops 3 sources, feeds a median core, buffers results.
// Latency: issue is combinational with src_valid; result reaches dst LAT+1 cycles after its issue.
// Backpressure: issues gated by credit (buffer free slots minus in-flight); dst_ready only stalls the drain.
// Optional build macro MEDIAN_STREAM_CTRL_STATS_EN adds the stall_cycles output.
module median_stream_ctrl
  import median_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LAT       = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      count,
  input  logic [2:0]       src_valid,
  input  logic [WIDTH-1:0] src_data0,
  input  logic [WIDTH-1:0] src_data1,
  input  logic [WIDTH-1:0] src_data2,
  output logic             src_pop,
  output logic             med_rst_n,
  output logic [WIDTH-1:0] med_word0,
  output logic [WIDTH-1:0] med_word1,
  output logic [WIDTH-1:0] med_word2,
  input  logic [WIDTH-1:0] med_word,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data,
  input  logic             dst_ready,
  output logic             busy,
`ifdef MEDIAN_STREAM_CTRL_STATS_EN
  output logic [31:0]      stall_cycles,
`endif
  output logic             done
);

  localparam int OCC_W = $clog2(OUT_DEPTH) + 1;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        count_q;
  logic [31:0]        issued_q;
  logic               all_issued;
  logic               start_acc;
  logic               credit_ok;
  logic               issue;
  logic               push;
  logic [CNT_W-1:0]   inflight;
  logic [OCC_W-1:0]   occ;
  logic               buf_empty;

  assign start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign all_issued = (issued_q == count_q);
  assign credit_ok  = (CNT_W'(occ) + inflight) < CNT_W'(OUT_DEPTH);
  assign issue      = (state_q == ST_RUN) && (&src_valid) && !all_issued && credit_ok;

  generate
    if (LAT == 0) begin : g_lat0
      assign inflight = '0;
      assign push     = issue;
    end else begin : g_latn
      logic [LAT-1:0] vld_sr;
      // Issue tags age one stage per cycle; the last stage marks med_word as valid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_sr <= '0;
        end else begin
          vld_sr[0] <= issue;
          for (int i = 1; i < LAT; i++) vld_sr[i] <= vld_sr[i-1];
        end
      end
      // Count outstanding core results; they already own a buffer slot.
      always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + CNT_W'(vld_sr[i]);
      end
      assign push = vld_sr[LAT-1];
    end
  endgenerate

  median_res_fifo #(
    .WIDTH     (WIDTH),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (med_word),
    .pop       (dst_ready),
    .pop_data  (dst_data),
    .empty     (buf_empty),
    .occ       (occ)
  );

  assign dst_valid = !buf_empty;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a zero-length job skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = (count != '0) ? ST_CLR : ST_DONE;
      ST_CLR:           state_d = ST_RUN;
      ST_RUN:           if (all_issued) state_d = ST_DRAIN;
      ST_DRAIN:         if ((inflight == '0) && buf_empty) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Output decode; operands are only driven on an issue cycle.
  always_comb begin
    src_pop   = 1'b0;
    med_word0 = '0;
    med_word1 = '0;
    med_word2 = '0;
    busy      = 1'b0;
    done      = 1'b0;
    med_rst_n = !rst;
    case (state_q)
      ST_CLR: begin
        busy      = 1'b1;
        med_rst_n = 1'b0;
      end
      ST_RUN: begin
        busy    = 1'b1;
        src_pop = issue;
        if (issue) begin
          med_word0 = src_data0;
          med_word1 = src_data1;
          med_word2 = src_data2;
        end
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Job length capture and issue counter; issue stops at count so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      issued_q <= '0;
    end else if (start_acc) begin
      count_q  <= count;
      issued_q <= '0;
    end else if (issue) begin
      issued_q <= issued_q + 1'b1;
    end
  end

`ifdef MEDIAN_STREAM_CTRL_STATS_EN
  // RUN cycles that wanted to issue but could not; saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (start_acc) begin
      stall_cycles <= '0;
    end else if ((state_q == ST_RUN) && !all_issued && !issue && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_median_stream_ctrl.sv
// tb_median_stream_ctrl: directed checks of the median stream controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_median_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0;
  logic        start_a;
  logic [31:0] count;
  logic [2:0]  src_valid0;
  logic        dst_ready0;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [31:0] med3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] lo, hi, m;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    m  = (hi < c) ? hi : c;
    return (lo > m) ? lo : m;
  endfunction

  function automatic logic [31:0] srcv(input int k, input int j);
    int v;
    v = (k * 7 + j * 13 + k * j * 5) % 29;
    return 32'(v);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- main instance: LAT=1, OUT_DEPTH=4 ----------------
  logic [31:0] ta [16];
  logic [31:0] tb [16];
  logic [31:0] tc [16];
  int idx0 = 0, base0 = 0, pops0 = 0, mrl0 = 0, nres0 = 0, cyc = 0;
  logic [31:0] res0 [256];
  logic [31:0] sd0_0, sd1_0, sd2_0, w0_0, w1_0, w2_0, mw_0, dd_0, p0;
  logic        src_pop0, med_rst_n0, dst_valid0, busy0, done0;
`ifdef MEDIAN_STREAM_CTRL_STATS_EN
  logic [31:0] stall0, stall1, stall2;
`endif

  assign sd0_0 = ta[4'(idx0 - base0)];
  assign sd1_0 = tb[4'(idx0 - base0)];
  assign sd2_0 = tc[4'(idx0 - base0)];

  // Median core model with one cycle of latency.
  always @(posedge clk) p0 <= med3(w0_0, w1_0, w2_0);
  assign mw_0 = p0;

  median_stream_ctrl #(.WIDTH(32), .LAT(1), .OUT_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .start(start0), .count(count), .src_valid(src_valid0),
    .src_data0(sd0_0), .src_data1(sd1_0), .src_data2(sd2_0), .src_pop(src_pop0),
    .med_rst_n(med_rst_n0), .med_word0(w0_0), .med_word1(w1_0), .med_word2(w2_0),
    .med_word(mw_0), .dst_valid(dst_valid0), .dst_data(dd_0), .dst_ready(dst_ready0),
    .busy(busy0),
`ifdef MEDIAN_STREAM_CTRL_STATS_EN
    .stall_cycles(stall0),
`endif
    .done(done0));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (src_pop0) begin
      idx0  <= idx0 + 1;
      pops0 <= pops0 + 1;
    end
    if (dst_valid0 && dst_ready0) begin
      res0[nres0[7:0]] <= dd_0;
      nres0 <= nres0 + 1;
    end
    if (!rst && !med_rst_n0) mrl0 <= mrl0 + 1;
  end

  // ---------------- aux instances: LAT=0/D=4 and LAT=8/D=16 ----------------
  logic [31:0] w0_1, w1_1, w2_1, mw_1, dd_1;
  logic [31:0] w0_2, w1_2, w2_2, mw_2, dd_2;
  logic [31:0] p2 [8];
  logic        src_pop1, med_rst_n1, dst_valid1, busy1, done1;
  logic        src_pop2, med_rst_n2, dst_valid2, busy2, done2;
  int npop1 = 0, first1 = 0, last1 = 0, nres1 = 0;
  int npop2 = 0, first2 = 0, last2 = 0, nres2 = 0;
  logic [31:0] res1 [32];
  logic [31:0] res2 [32];

  assign mw_1 = med3(w0_1, w1_1, w2_1);
  always @(posedge clk) begin
    p2[0] <= med3(w0_2, w1_2, w2_2);
    for (int i = 1; i < 8; i++) p2[i] <= p2[i-1];
  end
  assign mw_2 = p2[7];

  median_stream_ctrl #(.WIDTH(32), .LAT(0), .OUT_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .start(start_a), .count(count), .src_valid(3'b111),
    .src_data0(srcv(npop1, 0)), .src_data1(srcv(npop1, 1)), .src_data2(srcv(npop1, 2)),
    .src_pop(src_pop1), .med_rst_n(med_rst_n1), .med_word0(w0_1), .med_word1(w1_1),
    .med_word2(w2_1), .med_word(mw_1), .dst_valid(dst_valid1), .dst_data(dd_1),
    .dst_ready(1'b1), .busy(busy1),
`ifdef MEDIAN_STREAM_CTRL_STATS_EN
    .stall_cycles(stall1),
`endif
    .done(done1));

  median_stream_ctrl #(.WIDTH(32), .LAT(8), .OUT_DEPTH(16)) u2 (
    .clk(clk), .rst(rst), .start(start_a), .count(count), .src_valid(3'b111),
    .src_data0(srcv(npop2, 0)), .src_data1(srcv(npop2, 1)), .src_data2(srcv(npop2, 2)),
    .src_pop(src_pop2), .med_rst_n(med_rst_n2), .med_word0(w0_2), .med_word1(w1_2),
    .med_word2(w2_2), .med_word(mw_2), .dst_valid(dst_valid2), .dst_data(dd_2),
    .dst_ready(1'b1), .busy(busy2),
`ifdef MEDIAN_STREAM_CTRL_STATS_EN
    .stall_cycles(stall2),
`endif
    .done(done2));

  always @(posedge clk) begin
    if (src_pop1) begin
      if (npop1 == 0) first1 <= cyc;
      last1 <= cyc;
      npop1 <= npop1 + 1;
    end
    if (dst_valid1) begin
      res1[nres1[4:0]] <= dd_1;
      nres1 <= nres1 + 1;
    end
    if (src_pop2) begin
      if (npop2 == 0) first2 <= cyc;
      last2 <= cyc;
      npop2 <= npop2 + 1;
    end
    if (dst_valid2) begin
      res2[nres2[4:0]] <= dd_2;
      nres2 <= nres2 + 1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int p, r, m;
    rst        = 1'b1;
    start0     = 1'b0;
    start_a    = 1'b0;
    count      = '0;
    src_valid0 = 3'b111;
    dst_ready0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ta[i] = 32'(i * 3 + 1);
      tb[i] = 32'(40 - i * 2);
      tc[i] = 32'((i * 11) % 17);
    end
    ta[0] = 32'd5; tb[0] = 32'd1; tc[0] = 32'd9;
    ta[1] = 32'd2; tb[1] = 32'd8; tc[1] = 32'd4;
    ta[2] = 32'd7; tb[2] = 32'd7; tc[2] = 32'd3;
    step;
    step;

    // Reset values.
    chk("rst_src_pop", {31'd0, src_pop0}, 32'd0);
    chk("rst_med_rst_n", {31'd0, med_rst_n0}, 32'd0);
    chk("rst_med_word0", w0_0, 32'd0);
    chk("rst_dst_valid", {31'd0, dst_valid0}, 32'd0);
    chk("rst_dst_data", dd_0, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    rst = 1'b0;
    step;
    chk("idle_med_rst_n", {31'd0, med_rst_n0}, 32'd1);
    chk("idle_done", {31'd0, done0}, 32'd0);

    // Zero-length job: straight to DONE, no pop, no core reset.
    p = pops0; m = mrl0;
    count = 32'd0; start0 = 1'b1;
    step;
    start0 = 1'b0;
    chk("zero_done", {31'd0, done0}, 32'd1);
    chk("zero_busy", {31'd0, busy0}, 32'd0);
    repeat (3) step;
    chk("zero_pops", 32'(pops0 - p), 32'd0);
    chk("zero_medrst", 32'(mrl0 - m), 32'd0);

    // Three medians with immediate consumer.
    base0 = idx0; r = nres0;
    count = 32'd3; start0 = 1'b1;
    step;
    start0 = 1'b0;
    chk("j3_done_drop", {31'd0, done0}, 32'd0);
    chk("j3_busy", {31'd0, busy0}, 32'd1);
    chk("j3_clr_medrst", {31'd0, med_rst_n0}, 32'd0);
    for (int i = 0; i < 100 && !done0; i++) step;
    chk("j3_done", {31'd0, done0}, 32'd1);
    chk("j3_nres", 32'(nres0 - r), 32'd3);
    chk("j3_res0", res0[8'(r)], 32'd5);
    chk("j3_res1", res0[8'(r + 1)], 32'd4);
    chk("j3_res2", res0[8'(r + 2)], 32'd7);

    // Consumer stalled: credit limits issues to buffer depth.
    base0 = idx0; r = nres0; p = pops0;
    dst_ready0 = 1'b0;
    count = 32'd10; start0 = 1'b1;
    step;
    start0 = 1'b0;
    repeat (30) step;
    chk("bp_pops", 32'(pops0 - p), 32'd4);
    chk("bp_dst_valid", {31'd0, dst_valid0}, 32'd1);
    chk("bp_busy", {31'd0, busy0}, 32'd1);
    dst_ready0 = 1'b1;
    for (int i = 0; i < 200 && !done0; i++) step;
    chk("bp_done", {31'd0, done0}, 32'd1);
    chk("bp_nres", 32'(nres0 - r), 32'd10);
    chk("bp_pops_all", 32'(pops0 - p), 32'd10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("bp_res%0d", k), res0[8'(r + k)], med3(ta[k], tb[k], tc[k]));

    // One source missing for five RUN cycles.
    base0 = idx0; r = nres0; p = pops0;
    count = 32'd1; src_valid0 = 3'b101; start0 = 1'b1;
    step;
    start0 = 1'b0;
    step;
    repeat (5) step;
    chk("stall_no_pop", 32'(pops0 - p), 32'd0);
    chk("stall_src_pop", {31'd0, src_pop0}, 32'd0);
    src_valid0 = 3'b111;
    for (int i = 0; i < 100 && !done0; i++) step;
    chk("stall_done", {31'd0, done0}, 32'd1);
    chk("stall_pops", 32'(pops0 - p), 32'd1);
    chk("stall_res", res0[8'(r)], 32'd5);
`ifdef MEDIAN_STREAM_CTRL_STATS_EN
    chk("stall_cycles", stall0, 32'd5);
`endif

    // Reset in the middle of a job.
    base0 = idx0; p = pops0;
    count = 32'd6; start0 = 1'b1;
    step;
    start0 = 1'b0;
    for (int i = 0; i < 50 && (pops0 - p) < 2; i++) step;
    chk("mid_pops", 32'(pops0 - p), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_src_pop", {31'd0, src_pop0}, 32'd0);
    chk("mid_med_rst_n", {31'd0, med_rst_n0}, 32'd0);
    chk("mid_med_word0", w0_0, 32'd0);
    chk("mid_dst_valid", {31'd0, dst_valid0}, 32'd0);
    chk("mid_dst_data", dd_0, 32'd0);
    chk("mid_busy", {31'd0, busy0}, 32'd0);
    chk("mid_done", {31'd0, done0}, 32'd0);
    r = nres0;
    step;
    rst = 1'b0;
    repeat (20) step;
    chk("post_nres", 32'(nres0 - r), 32'd0);
    chk("post_busy", {31'd0, busy0}, 32'd0);
    chk("post_pops", 32'(pops0 - p), 32'd2);

    // LAT=0 and LAT=8 builds sustain one issue per cycle.
    count = 32'd20; start_a = 1'b1;
    step;
    start_a = 1'b0;
    for (int i = 0; i < 300 && !(done1 && done2); i++) step;
    chk("l0_done", {31'd0, done1}, 32'd1);
    chk("l8_done", {31'd0, done2}, 32'd1);
    chk("l0_pops", 32'(npop1), 32'd20);
    chk("l8_pops", 32'(npop2), 32'd20);
    chk("l0_span", 32'(last1 - first1), 32'd19);
    chk("l8_span", 32'(last2 - first2), 32'd19);
    chk("l0_nres", 32'(nres1), 32'd20);
    chk("l8_nres", 32'(nres2), 32'd20);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("l0_res%0d", k), res1[k], med3(srcv(k, 0), srcv(k, 1), srcv(k, 2)));
      chk($sformatf("l8_res%0d", k), res2[k], med3(srcv(k, 0), srcv(k, 1), srcv(k, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/median_stream_ctrl.md
MEDIAN_STREAM_CTRL -- requirements
Module: median_stream_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, data word width for all stream and median-core ports.
REQ-002 Parameter LAT, default 1, median-core latency in cycles from word0..2 presented to median_word valid (legal 0..8).
REQ-003 Parameter OUT_DEPTH, default 4, result buffer depth (power of two, 2..16).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  begin a job; sampled only in IDLE.
REQ-007 count  in  32  number of medians in the job; sampled with start.
REQ-008 src_valid  in  3  per-source word available, bit i for source i.
REQ-009 src_data0/1/2  in  WIDTH each  source words.
REQ-010 src_pop  out  1  pops all three sources together.
REQ-011 med_rst_n  out  1  median-core reset, active-low.
REQ-012 med_word0/1/2  out  WIDTH each  operands to median core.
REQ-013 med_word  in  WIDTH  median-core result.
REQ-014 dst_valid  out  1  result available; dst_data  out  WIDTH  result; dst_ready  in  1  consumer accepts.
REQ-015 busy  out  1  job in progress; done  out  1  job complete.

Function
REQ-016 FSM states IDLE, CLR, RUN, DRAIN, DONE; encoding from shared package.
REQ-017 IDLE: start=1 and count!=0 -> CLR; start=1 and count==0 -> DONE; otherwise stay.
REQ-018 CLR lasts exactly one cycle, med_rst_n=0, then -> RUN; med_rst_n=1 in all other non-reset states.
REQ-019 RUN: issue when all src_valid bits =1, issued<count, credit>0; issue cycle asserts src_pop=1 and drives med_word0..2 = src_data0..2 combinationally.
REQ-020 src_pop SHALL never assert with any src_valid bit low; med_word0..2 = 0 when not issuing.
REQ-021 Credit = OUT_DEPTH - buffer occupancy - in-flight issues; at most one issue per cycle; back-to-back issues allowed.
REQ-022 Issue tag travels through LAT-stage valid shift register; at stage LAT med_word is written to buffer (LAT=0: same cycle as issue).
REQ-023 Buffer FIFO order; dst_valid = not empty; pop on dst_valid&&dst_ready; simultaneous push/pop at full or empty legal, occupancy unchanged.
REQ-024 issued counter 32-bit, reaches count=0xFFFFFFFF without wrap; RUN -> DRAIN when issued==count.
REQ-025 DRAIN -> DONE when in-flight==0 and buffer empty.
REQ-026 DONE: done=1, busy=0; held until start=1 -> next job per REQ-017 (done drops the following cycle).
REQ-027 busy=1 in CLR, RUN, DRAIN only.
REQ-028 start outside IDLE/DONE ignored; count changes mid-job ignored.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, counters/buffer/shift register clear, in-flight results discarded.
REQ-030 Output values under reset: src_pop=0, med_rst_n=0, med_word0..2=0, dst_valid=0, dst_data=0, busy=0, done=0.
REQ-031 Reset mid-job SHALL drop the job; no result emitted after release until a new start.

Configuration
REQ-032 Macro MEDIAN_STREAM_CTRL_STATS_EN defined: extra output stall_cycles (32, reset 0) counts RUN cycles with no issue while issued<count; cleared on each accepted start; saturates at 0xFFFFFFFF.
REQ-033 Macro undefined: stall_cycles port and counter absent; all other behaviour identical.

Structure
REQ-034 Package median_ctrl_pkg holds FSM state typedef and LAT/OUT_DEPTH limit constants.
REQ-035 One sub-module median_res_fifo (parameterised WIDTH/OUT_DEPTH result buffer); shift register and FSM stay in top.

Verification
REQ-036 count=3, sources (5,1,9),(2,8,4),(7,7,3), bench median model LAT=1, dst_ready=1 -> dst_data 5,4,7 in order, done=1 after last.
REQ-037 count=0 with start -> DONE next cycle, src_pop never asserted, med_rst_n never low.
REQ-038 count=10, dst_ready=0 throughout, OUT_DEPTH=4 -> exactly 4 pops, dst_valid=1, busy=1; dst_ready=1 -> all 10 delivered.
REQ-039 src_valid=3'b101 for 5 cycles then 3'b111 -> no src_pop during the 5 cycles; with STATS_EN stall_cycles=5.
REQ-040 rst pulsed after 2 of count=6 issues -> all outputs at reset values immediately, no dst_valid until new start.
REQ-041 LAT=0 and LAT=8 builds, count=20 continuous sources, dst_ready=1 -> one issue per cycle sustained, 20 results, order kept.
